// File: rtl/aibcr3aux_osc_dly_pkg.sv
// Shared types and constants for the oscillator delay-chain sequencer.
// Optional BIST window check is enabled with AIBCR3AUX_OSC_DLY_SEQ_BIST_EN.
package aibcr3aux_osc_dly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CLEAR_CYC   = 2;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/aibcr3aux_osc_dly_sync.sv
// Brings the asynchronous chain tap into the cp domain and emits a
// one-cycle pulse on each synchronized rising edge.
module aibcr3aux_osc_dly_sync
    import aibcr3aux_osc_dly_pkg::*;
(
    input  logic cp,
    input  logic cd,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge cp or posedge cd) begin
        if (cd) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/aibcr3aux_osc_dly_seq.sv
// Clear/load/measure sequencer for a scan-loadable delay chain.
// Define AIBCR3AUX_OSC_DLY_SEQ_BIST_EN to add the cnt_min_i/cnt_max_i pass check.
module aibcr3aux_osc_dly_seq
    import aibcr3aux_osc_dly_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WIN_W     = 12,
    parameter int CNT_W     = 12
) (
    input  logic                 cp,
    input  logic                 cd,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CHAIN_LEN-1:0] pat_i,
    input  logic [WIN_W-1:0]     win_i,
    input  logic                 dly_q_i,
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
    input  logic [CNT_W-1:0]     cnt_min_i,
    input  logic [CNT_W-1:0]     cnt_max_i,
`endif
    output logic                 dly_cdn_o,
    output logic                 dly_se_n_o,
    output logic                 dly_si_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     cnt_o,
    output logic                 ovf_o,
    output logic                 pass_o
);

    // One phase counter serves CLEAR, LOAD and RUN, so it must cover the longest.
    localparam int CYW = (WIN_W > $clog2(CHAIN_LEN) + 1) ? WIN_W : $clog2(CHAIN_LEN) + 1;

    state_t               state_q, state_d;
    logic [CYW-1:0]       cyc_q, cyc_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 rise;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
    logic [CNT_W-1:0]     min_q, min_d;
    logic [CNT_W-1:0]     max_q, max_d;
    logic                 pass_q, pass_d;
`endif

    aibcr3aux_osc_dly_sync u_sync (
        .cp     (cp),
        .cd     (cd),
        .d_i    (dly_q_i),
        .rise_o (rise)
    );

    always_ff @(posedge cp or posedge cd) begin
        if (cd) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            pat_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
            min_q   <= '0;
            max_q   <= '0;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pat_q   <= pat_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
            min_q   <= min_d;
            max_q   <= max_d;
            pass_q  <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pat_d   = pat_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
        min_d   = min_q;
        max_d   = max_q;
        pass_d  = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                    cyc_d   = '0;
                    pat_d   = pat_i;
                    win_d   = win_i;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
                    min_d   = cnt_min_i;
                    max_d   = cnt_max_i;
                    pass_d  = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                if (cyc_q == CYW'(CLEAR_CYC - 1)) begin
                    state_d = ST_LOAD;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYW'(1);
                end
            end
            ST_LOAD: begin
                pat_d = pat_q >> 1;
                if (cyc_q == CYW'(CHAIN_LEN - 1)) begin
                    state_d = (win_q == '0) ? ST_DONE : ST_RUN;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYW'(1);
                end
            end
            ST_RUN: begin
                if (rise) begin
                    if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
                    else                        cnt_d = cnt_q + CNT_W'(1);
                end
                if (cyc_q == CYW'(win_q) - CYW'(1)) begin
                    state_d = ST_DONE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort_i && (state_q == ST_CLEAR || state_q == ST_LOAD || state_q == ST_RUN)) begin
            state_d = ST_IDLE;
        end

`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
        // Judged on the final count so pass_o becomes valid alongside done_o.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            pass_d = (cnt_d >= min_q) && (cnt_d <= max_q) && !ovf_d;
        end
`endif
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign dly_cdn_o  = !(state_q == ST_IDLE || state_q == ST_CLEAR);
    assign dly_se_n_o = (state_q != ST_LOAD);
    assign dly_si_o   = (state_q == ST_LOAD) ? pat_q[0] : 1'b0;
    assign cnt_o      = cnt_q;
    assign ovf_o      = ovf_q;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
    assign pass_o     = pass_q;
`else
    assign pass_o     = 1'b0;
`endif

endmodule

// File: tb/tb_aibcr3aux_osc_dly_seq.sv
// Directed bench for aibcr3aux_osc_dly_seq: a 12-bit and a 4-bit counter
// instance driven in lockstep (build with AIBCR3AUX_OSC_DLY_SEQ_BIST_EN for pass_o).
module tb_aibcr3aux_osc_dly_seq;

    logic        cp;
    logic        cd;
    logic        start_i;
    logic        abort_i;
    logic [7:0]  pat_i;
    logic [11:0] win_i;
    logic        dly_q_i;
    logic [11:0] cnt_min_i, cnt_max_i;
    logic [3:0]  min4_i, max4_i;

    logic        dly_cdn_o, dly_se_n_o, dly_si_o, busy_o, done_o, ovf_o, pass_o;
    logic [11:0] cnt_o;
    logic        cdn4, sen4, si4, busy4, done4, ovf4, pass4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    aibcr3aux_osc_dly_seq #(.CHAIN_LEN(8), .WIN_W(12), .CNT_W(12)) dut (
        .cp(cp), .cd(cd), .start_i(start_i), .abort_i(abort_i),
        .pat_i(pat_i), .win_i(win_i), .dly_q_i(dly_q_i),
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
        .cnt_min_i(cnt_min_i), .cnt_max_i(cnt_max_i),
`endif
        .dly_cdn_o(dly_cdn_o), .dly_se_n_o(dly_se_n_o), .dly_si_o(dly_si_o),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o), .ovf_o(ovf_o), .pass_o(pass_o)
    );

    aibcr3aux_osc_dly_seq #(.CHAIN_LEN(8), .WIN_W(12), .CNT_W(4)) dut4 (
        .cp(cp), .cd(cd), .start_i(start_i), .abort_i(abort_i),
        .pat_i(pat_i), .win_i(win_i), .dly_q_i(dly_q_i),
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
        .cnt_min_i(min4_i), .cnt_max_i(max4_i),
`endif
        .dly_cdn_o(cdn4), .dly_se_n_o(sen4), .dly_si_o(si4),
        .busy_o(busy4), .done_o(done4), .cnt_o(cnt4), .ovf_o(ovf4), .pass_o(pass4)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        logic [7:0] pat;
        int         win;
        int         half;
        int         cnt;
        bit         ovf;
        int         cnt4;
        bit         ovf4;
        bit         pass;
        bit         pass4;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        bit         ok_clear, ok_load, ok_run, ok_idle;
        logic [7:0] si_seen;
        bit         exp_p, exp_p4;
`ifdef AIBCR3AUX_OSC_DLY_SEQ_BIST_EN
        exp_p  = v.pass;
        exp_p4 = v.pass4;
`else
        exp_p  = 1'b0;
        exp_p4 = 1'b0;
`endif
        tick();
        pat_i   = v.pat;
        win_i   = v.win[11:0];
        start_i = 1'b1;
        dly_q_i = 1'b0;
        tick();
        start_i = 1'b0;
        pat_i   = ~v.pat;
        ok_clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!(dly_cdn_o == 1'b0 && dly_se_n_o == 1'b1 && busy_o == 1'b1)) ok_clear = 1'b0;
            tick();
        end
        check("clear_phase", 32'(ok_clear), 32'd1);
        ok_load = 1'b1;
        si_seen = '0;
        for (int k = 0; k < 8; k++) begin
            si_seen[k] = dly_si_o;
            if (!(dly_cdn_o == 1'b1 && dly_se_n_o == 1'b0 && busy_o == 1'b1)) ok_load = 1'b0;
            // start while busy must not relatch pat_i (now the complement)
            start_i = (k == 2 || k == 3);
            tick();
        end
        start_i = 1'b0;
        check("load_si_seq", 32'(si_seen), 32'(v.pat));
        check("load_ctl", 32'(ok_load), 32'd1);
        ok_run = 1'b1;
        for (int r = 0; r < v.win; r++) begin
            if (v.half > 0) dly_q_i = ((r / v.half) % 2) == 0;
            if (!(dly_cdn_o && dly_se_n_o && !dly_si_o && busy_o && !done_o)) ok_run = 1'b0;
            tick();
        end
        dly_q_i = 1'b0;
        if (v.win > 0) check("run_ctl", 32'(ok_run), 32'd1);
        check("done_pulse", 32'(done_o), 32'd1);
        check("cnt", 32'(cnt_o), 32'(v.cnt));
        check("ovf", 32'(ovf_o), 32'(v.ovf));
        check("cnt4", 32'(cnt4), 32'(v.cnt4));
        check("ovf4", 32'(ovf4), 32'(v.ovf4));
        check("pass", 32'(pass_o), 32'(exp_p));
        check("pass4", 32'(pass4), 32'(exp_p4));
        tick();
        ok_idle = (done_o == 1'b0 && busy_o == 1'b0 && dly_cdn_o == 1'b0 && dly_se_n_o == 1'b1);
        check("idle_after_done", 32'(ok_idle), 32'd1);
        check("cnt_hold", 32'(cnt_o), 32'(v.cnt));
        check("pass_hold", 32'(pass_o), 32'(exp_p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        //             pat    win  half cnt ovf cnt4 ovf4 pass pass4
        vecs[0] = '{8'hA5,   0,  0,   0, 0,   0, 0,   0, 0};
        vecs[1] = '{8'h3C, 100,  5,  10, 0,  10, 0,   1, 1};
        vecs[2] = '{8'hFF, 130,  5,  13, 0,  13, 0,   0, 0};
        vecs[3] = '{8'h00,  20,  2,   5, 0,   5, 0,   0, 0};
        vecs[4] = '{8'h5A,   1,  1,   0, 0,   0, 0,   0, 0};
        vecs[5] = '{8'h81, 200,  4,  25, 0,  15, 1,   0, 0};

        cd = 1'b1; start_i = 1'b0; abort_i = 1'b0; pat_i = '0; win_i = '0; dly_q_i = 1'b0;
        cnt_min_i = 12'd8; cnt_max_i = 12'd12; min4_i = 4'd8; max4_i = 4'd12;
        #1;
        check("rst_cdn", 32'(dly_cdn_o), 32'd0);
        check("rst_se_n", 32'(dly_se_n_o), 32'd1);
        check("rst_busy_done", 32'({busy_o, done_o, dly_si_o}), 32'd0);
        check("rst_cnt_ovf_pass", 32'({cnt_o, ovf_o, pass_o}), 32'd0);
        tick(); tick();
        cd = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in IDLE clears the held result immediately.
        cd = 1'b1;
        #1;
        check("idle_rst_cnt", 32'(cnt_o), 32'd0);
        check("idle_rst_cnt4_ovf4", 32'({cnt4, ovf4}), 32'd0);
        tick();
        cd = 1'b0;

        // Abort on RUN cycle 3: partial count kept, no done pulse.
        tick();
        pat_i = 8'h0F; win_i = 12'd50; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        for (int r = 0; r < 4; r++) begin
            dly_q_i = ((r % 2) == 0);
            abort_i = (r == 3);
            tick();
        end
        abort_i = 1'b0;
        dly_q_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_cdn", 32'(dly_cdn_o), 32'd0);
        check("abort_cnt_partial", 32'(cnt_o), 32'd1);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done_o) saw_done = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_edge_discarded", 32'(cnt_o), 32'd1);
        run_vec(vecs[1]);

        // Reset during LOAD cycle 4 (pattern bit 4 is 1 so si is high there).
        tick();
        pat_i = 8'hD3; win_i = 12'd20; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_si", 32'(dly_si_o), 32'd1);
        #2;
        cd = 1'b1;
        #1;
        check("mid_rst_cdn", 32'(dly_cdn_o), 32'd0);
        check("mid_rst_se_n", 32'(dly_se_n_o), 32'd1);
        check("mid_rst_si", 32'(dly_si_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done_cnt_ovf_pass", 32'({done_o, cnt_o, ovf_o, pass_o}), 32'd0);
        tick();
        cd = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done_o || busy_o) saw_done = 1'b1;
            tick();
        end
        check("mid_rst_discarded", 32'(saw_done), 32'd0);
        run_vec(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aibcr3aux_osc_dly_seq.md
AIBCR3AUX_OSC_DLY_SEQ -- requirements
Module: aibcr3aux_osc_dly_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CHAIN_LEN, 8, number of scan bits in the controlled delay-unit chain.
REQ-002 WIN_W, 12, width of the measurement-window length.
REQ-003 CNT_W, 12, width of the edge-count result.
REQ-004 The block SHALL have these ports (name, direction, width, meaning): cp, input, 1, single clock; all logic is on its rising edge.
REQ-005 cd, input, 1, reset; asynchronous, active-high.
REQ-006 start_i, input, 1, request one clear/load/measure sequence.
REQ-007 abort_i, input, 1, abandon the sequence in progress.
REQ-008 pat_i, input, CHAIN_LEN, scan pattern to preload into the chain.
REQ-009 win_i, input, WIN_W, RUN window length in cp cycles.
REQ-010 dly_q_i, input, 1, chain tap output; asynchronous to cp.
REQ-011 dly_cdn_o, output, 1, chain clear; active-low.
REQ-012 dly_se_n_o, output, 1, chain scan enable; active-low.
REQ-013 dly_si_o, output, 1, chain scan data.
REQ-014 busy_o, output, 1, sequence in progress.
REQ-015 done_o, output, 1, one-cycle completion pulse.
REQ-016 cnt_o, output, CNT_W, rising-edge count measured in the last RUN.
REQ-017 ovf_o, output, 1, count saturated.
REQ-018 pass_o, output, 1, BIST result (see Configuration).

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, LOAD, RUN and DONE; busy_o SHALL be 1 in every state except IDLE.
REQ-020 In IDLE, start_i=1 SHALL move the FSM to CLEAR next cycle, latch pat_i and win_i, and zero cnt_o and ovf_o; start_i in any other state SHALL be ignored.
REQ-021 CLEAR SHALL last exactly 2 cycles with dly_cdn_o=0 and dly_se_n_o=1, then go to LOAD.
REQ-022 LOAD SHALL last exactly CHAIN_LEN cycles with dly_cdn_o=1 and dly_se_n_o=0, driving dly_si_o = latched pat bit k on LOAD cycle k (k=0 first, LSB first).
REQ-023 RUN SHALL last exactly the latched win cycles with dly_se_n_o=1, dly_si_o=0 and dly_cdn_o=1; a latched win=0 SHALL go from LOAD directly to DONE.
REQ-024 dly_q_i SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-025 cnt_o SHALL increment by 1 per detected edge only while in RUN; detected edges outside RUN SHALL be discarded.
REQ-026 cnt_o SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set ovf_o, which is sticky until the next accepted start.
REQ-027 DONE SHALL last 1 cycle with done_o=1, then return to IDLE; cnt_o, ovf_o and pass_o SHALL hold until the next accepted start.
REQ-028 abort_i=1 in CLEAR, LOAD or RUN SHALL force IDLE on the next cycle, with no done_o and with cnt_o holding its partial value.
REQ-029 abort_i SHALL take priority over every state transition.
REQ-030 In IDLE, dly_cdn_o SHALL be 0 so the chain is held cleared.

Reset
REQ-031 Asserting cd SHALL immediately force: state=IDLE, dly_cdn_o=0, dly_se_n_o=1, dly_si_o=0, busy_o=0, done_o=0, cnt_o=0, ovf_o=0, pass_o=0, and both synchronizer flops=0.
REQ-032 Reset asserted mid-sequence SHALL discard the sequence with no done_o.

Configuration
REQ-033 With AIBCR3AUX_OSC_DLY_SEQ_BIST_EN defined, the block SHALL add inputs cnt_min_i[CNT_W] and cnt_max_i[CNT_W], sampled at start.
REQ-034 With the macro defined, in DONE pass_o SHALL equal (cnt_min <= cnt_o <= cnt_max) AND NOT ovf_o, registered with done_o.
REQ-035 Without the macro, the cnt_min_i and cnt_max_i ports SHALL be absent and pass_o SHALL be tied to 0.

Structure
REQ-036 Package aibcr3aux_osc_dly_pkg SHALL hold the FSM state enum and the constants CLEAR_CYC=2 and SYNC_STAGES=2.
REQ-037 Sub-module aibcr3aux_osc_dly_sync SHALL implement the 2-flop synchronizer plus rising-edge pulse, with cp/cd ports.
REQ-038 All other logic (FSM, counters, pattern shifter) SHALL be in the top module.

Verification
REQ-039 Configure CHAIN_LEN=8, pat=8'hA5, win=0, then pulse start -> dly_cdn_o low for 2 cycles, dly_si_o sequence 1,0,1,0,0,1,0,1 with dly_se_n_o=0 for 8 cycles, done_o on the next cycle, cnt_o=0.
REQ-040 Set win=100 with dly_q_i toggling every 5 cp cycles from RUN start -> cnt_o=10 (tolerance ±1 for synchronizer latency), ovf_o=0.
REQ-041 Set CNT_W=4, win=200 and toggle dly_q_i every 4 cycles -> cnt_o=15, ovf_o=1.
REQ-042 Assert abort_i on RUN cycle 3 -> IDLE next cycle, no done_o, dly_cdn_o=0; a following start runs normally.
REQ-043 Assert cd during LOAD cycle 4 -> all outputs at reset values immediately; start pulses during busy_o are ignored.
REQ-044 Build with BIST_EN and set min=8, max=12 -> pass_o=1 for count 10; pass_o=0 for count 13 and for ovf_o=1.
